// File: rtl/im2_vector_responder.sv
// im2_vector_responder
//   Z80-side interrupt responder. Latches requests from three sources, holds
//   n_int low for the winning source, answers the M1+IORQ acknowledge cycle
//   with an IM2 vector byte, and tracks the in-service source.
//
//   Optional feature macro: RETI_DECODE_EN
//     defined   : opcode snoop for RETI (ED 4D); a source stays in service and
//                 blocks itself and lower-priority sources until RETI.
//     undefined : no snoop logic; in-service is released at acknowledge end
//                 (auto-EOI) and inservice reads 0.
//
// Ports
//   clk28        in   system clock, rising edge
//   rst_n        in   synchronous reset, active-low
//   clkcpu_ck    in   one-clk28 strobe per CPU clock rising edge
//   req_frame    in   frame interrupt pulse (priority 0, highest)
//   req_line     in   raster-line interrupt pulse (priority 1)
//   req_ext      in   external interrupt level (priority 2, lowest)
//   vec_base     in   runtime vector base [7:3]
//   vec_base_we  in   load vec_base
//   bus_m1       in   CPU M1 active
//   bus_iorq     in   CPU IORQ active
//   bus_mreq     in   CPU MREQ active
//   bus_rd       in   CPU RD active
//   bus_d        in   CPU data bus (opcode snoop)
//   n_int        out  interrupt request to CPU, active-low
//   d_out        out  vector byte
//   d_out_en     out  drive d_out onto the data bus
//   inservice    out  one-hot in-service source {ext,line,frame}

module im2_vector_responder #(
  parameter int unsigned INT_HOLD    = 32,
  parameter logic [7:0]  VECTOR_BASE = 8'hF8
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       clkcpu_ck,
  input  logic       req_frame,
  input  logic       req_line,
  input  logic       req_ext,
  input  logic [4:0] vec_base,
  input  logic       vec_base_we,
  input  logic       bus_m1,
  input  logic       bus_iorq,
  input  logic       bus_mreq,
  input  logic       bus_rd,
  input  logic [7:0] bus_d,
  output logic       n_int,
  output logic [7:0] d_out,
  output logic       d_out_en,
  output logic [2:0] inservice
);

  localparam int unsigned CW = $clog2(INT_HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    pend_q, pend_d;
  logic [4:0]    base_q, base_d;
  logic [1:0]    code_q, code_d;
  logic          n_int_q, n_int_d;
  logic [7:0]    dout_q, dout_d;
  logic          den_q, den_d;

  logic [2:0]    req_vec;
  logic [2:0]    eff_pend;
  logic [2:0]    mask;
  logic [2:0]    elig;
  logic          win_valid;
  logic [1:0]    win_code;
  logic [2:0]    win_oh;
  logic [2:0]    code_oh;
  logic [2:0]    pend_clr;
  logic          ack_cyc;
  logic          ack_exit;

  // Incoming requests take part in arbitration in the cycle they arrive so
  // n_int falls one clk28 after the request.
  always_comb begin
    req_vec  = {req_ext, req_line, req_frame};
    eff_pend = pend_q | req_vec;
    elig     = eff_pend & ~mask;
    win_valid = |elig;
    win_code = 2'd2;
    if (elig[0])      win_code = 2'd0;
    else if (elig[1]) win_code = 2'd1;
    win_oh  = 3'b001 << win_code;
    code_oh = 3'b001 << code_q;
    ack_cyc = bus_m1 & bus_iorq;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = vec_base_we ? vec_base : base_q;
    code_d   = code_q;
    n_int_d  = n_int_q;
    dout_d   = dout_q;
    den_d    = den_q;
    pend_clr = '0;
    ack_exit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d = S_REQ;
          n_int_d = 1'b0;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        if (!win_valid) begin
          state_d = S_IDLE;
          n_int_d = 1'b1;
        end else if (ack_cyc) begin
          code_d  = win_code;
          dout_d  = {base_q, win_code, 1'b0};
          den_d   = 1'b1;
          state_d = S_ACK;
        end else if (clkcpu_ck) begin
          if (cnt_q == CW'(INT_HOLD - 1)) begin
            pend_clr = win_oh;
            n_int_d  = 1'b1;
            state_d  = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ACK: begin
        if (!ack_cyc) begin
          ack_exit = 1'b1;
          pend_clr = code_oh;
          den_d    = 1'b0;
          n_int_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new request in the clearing cycle survives.
    pend_d = (pend_q & ~pend_clr) | req_vec;
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      base_q  <= VECTOR_BASE[7:3];
      code_q  <= '0;
      n_int_q <= 1'b1;
      dout_q  <= '0;
      den_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      base_q  <= base_d;
      code_q  <= code_d;
      n_int_q <= n_int_d;
      dout_q  <= dout_d;
      den_q   <= den_d;
    end
  end

  assign n_int    = n_int_q;
  assign d_out    = dout_q;
  assign d_out_en = den_q;

`ifdef RETI_DECODE_EN
  logic [2:0] is_q;
  logic [2:0] reti_clr;
  logic       fetch;
  logic       fetch_q;
  logic       fetch_rise;
  logic       saw_ed_q;
  logic       reti;

  always_comb begin
    fetch      = bus_m1 & bus_mreq & bus_rd;
    fetch_rise = fetch & ~fetch_q;
    reti       = fetch_rise && (bus_d == 8'h4D) && saw_ed_q;
    // Highest-priority in-service source is the one RETI returns from.
    reti_clr = '0;
    if (reti) begin
      if (is_q[0])      reti_clr = 3'b001;
      else if (is_q[1]) reti_clr = 3'b010;
      else if (is_q[2]) reti_clr = 3'b100;
    end
    mask = {|is_q[2:0], |is_q[1:0], is_q[0]};
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      fetch_q  <= 1'b0;
      saw_ed_q <= 1'b0;
      is_q     <= '0;
    end else begin
      fetch_q <= fetch;
      if (fetch_rise) saw_ed_q <= (bus_d == 8'hED);
      is_q <= (is_q & ~reti_clr) | (ack_exit ? code_oh : 3'b000);
    end
  end

  assign inservice = is_q;
`else
  logic unused_snoop;
  assign unused_snoop = ^{bus_mreq, bus_rd, bus_d, ack_exit};
  assign mask      = '0;
  assign inservice = '0;
`endif

endmodule

// File: tb/tb_im2_vector_responder.sv
module tb_im2_vector_responder;

  logic       clk28 = 1'b0;
  logic       rst_n;
  logic       clkcpu_ck;
  logic       req_frame, req_line, req_ext;
  logic [4:0] vec_base;
  logic       vec_base_we;
  logic       bus_m1, bus_iorq, bus_mreq, bus_rd;
  logic [7:0] bus_d;
  logic       n_int;
  logic [7:0] d_out;
  logic       d_out_en;
  logic [2:0] inservice;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb[$];

  im2_vector_responder #(.INT_HOLD(32), .VECTOR_BASE(8'hF8)) dut (
    .clk28(clk28), .rst_n(rst_n), .clkcpu_ck(clkcpu_ck),
    .req_frame(req_frame), .req_line(req_line), .req_ext(req_ext),
    .vec_base(vec_base), .vec_base_we(vec_base_we),
    .bus_m1(bus_m1), .bus_iorq(bus_iorq), .bus_mreq(bus_mreq), .bus_rd(bus_rd),
    .bus_d(bus_d), .n_int(n_int), .d_out(d_out), .d_out_en(d_out_en),
    .inservice(inservice)
  );

  initial forever #5 clk28 = ~clk28;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk28);
  endtask

  task automatic strobe(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      clkcpu_ck = 1'b1; tick();
      clkcpu_ck = 1'b0; tick();
    end
  endtask

  task automatic fetch(input logic [7:0] op);
    bus_m1 = 1'b1; bus_mreq = 1'b1; bus_rd = 1'b1; bus_d = op;
    tick();
    bus_m1 = 1'b0; bus_mreq = 1'b0; bus_rd = 1'b0; bus_d = 8'h00;
    tick();
  endtask

  task automatic reti();
    fetch(8'hED);
    fetch(8'h4D);
  endtask

  task automatic do_ack(input logic [7:0] exp_vec);
    sb.push_back(exp_vec);
    bus_m1 = 1'b1; bus_iorq = 1'b1;
    tick();
    check_eq("ack_den", d_out_en, 1);
    tick(); tick();
    check_eq("ack_hold_den", d_out_en, 1);
    check_eq("ack_hold_nint", n_int, 0);
    bus_m1 = 1'b0; bus_iorq = 1'b0;
    tick();
    check_eq("ack_end_den", d_out_en, 0);
    check_eq("ack_end_nint", n_int, 1);
  endtask

  task automatic pulse_frame();
    req_frame = 1'b1; tick(); req_frame = 1'b0;
  endtask

  // Vector scoreboard: each rising d_out_en must match the next queued vector.
  initial begin
    logic en_prev;
    en_prev = 1'b0;
    forever begin
      @(negedge clk28);
      if (d_out_en === 1'b1 && en_prev !== 1'b1) begin
        if (sb.size() == 0) check_eq("unexpected_vec", d_out_en, 0);
        else check_eq("vector", d_out, sb.pop_front());
      end
      en_prev = d_out_en;
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: timeout reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    rst_n = 1'b0; clkcpu_ck = 1'b0;
    req_frame = 1'b0; req_line = 1'b0; req_ext = 1'b0;
    vec_base = '0; vec_base_we = 1'b0;
    bus_m1 = 1'b0; bus_iorq = 1'b0; bus_mreq = 1'b0; bus_rd = 1'b0; bus_d = '0;
    repeat (3) tick();
    check_eq("rst_nint", n_int, 1);
    check_eq("rst_dout", d_out, 0);
    check_eq("rst_den", d_out_en, 0);
    check_eq("rst_insvc", inservice, 0);
    rst_n = 1'b1;
    tick();

    // Frame request acknowledged after 10 CPU clocks
    pulse_frame();
    check_eq("t1_nint_low", n_int, 0);
    strobe(10);
    check_eq("t1_nint_wait", n_int, 0);
    do_ack(8'hF8);
`ifdef RETI_DECODE_EN
    check_eq("t1_insvc", inservice, 3'b001);
    reti();
`endif
    check_eq("t1_insvc_clr", inservice, 0);

    // Unacknowledged request expires on the 32nd strobe
    pulse_frame();
    strobe(31);
    check_eq("t2_nint_31", n_int, 0);
    strobe(1);
    check_eq("t2_nint_32", n_int, 1);
    repeat (3) tick();
    check_eq("t2_stay_high", n_int, 1);

    // Simultaneous line+frame: frame first, then line
    req_frame = 1'b1; req_line = 1'b1; tick();
    req_frame = 1'b0; req_line = 1'b0;
    check_eq("t3_nint_low", n_int, 0);
    do_ack(8'hF8);
`ifdef RETI_DECODE_EN
    tick(); tick();
    check_eq("t3_masked", n_int, 1);
    check_eq("t3_insvc", inservice, 3'b001);
    reti();
    check_eq("t3_line_req", n_int, 0);
    do_ack(8'hFA);
    check_eq("t3_insvc_line", inservice, 3'b010);
    reti();
    check_eq("t3_insvc_clr", inservice, 0);
`else
    tick();
    check_eq("t3_line_req", n_int, 0);
    do_ack(8'hFA);
    check_eq("t3_insvc_auto", inservice, 0);
`endif

    // Runtime vector base with external source
    vec_base = 5'h10; vec_base_we = 1'b1; tick(); vec_base_we = 1'b0;
    req_ext = 1'b1; tick();
    check_eq("t4_nint_low", n_int, 0);
    req_ext = 1'b0;
    do_ack(8'h84);
`ifdef RETI_DECODE_EN
    check_eq("t4_insvc", inservice, 3'b100);
    reti();
`endif
    check_eq("t4_insvc_clr", inservice, 0);

    // Base written during ACK applies only to the following acknowledge
    pulse_frame();
    sb.push_back(8'h80);
    bus_m1 = 1'b1; bus_iorq = 1'b1; tick();
    vec_base = 5'h15; vec_base_we = 1'b1; tick(); vec_base_we = 1'b0; tick();
    check_eq("vb_hold", d_out, 8'h80);
    bus_m1 = 1'b0; bus_iorq = 1'b0; tick();
`ifdef RETI_DECODE_EN
    reti();
`endif
    pulse_frame();
    do_ack(8'hA8);
`ifdef RETI_DECODE_EN
    reti();

    // Nested: line blocked by frame in service until a true ED,4D
    pulse_frame();
    do_ack(8'hA8);
    req_line = 1'b1; tick(); req_line = 1'b0; tick();
    check_eq("t5_blocked", n_int, 1);
    fetch(8'hED); fetch(8'h00); fetch(8'h4D);
    check_eq("t5_ed00_nint", n_int, 1);
    check_eq("t5_ed00_insvc", inservice, 3'b001);
    fetch(8'hED); fetch(8'hDD); fetch(8'h4D);
    check_eq("t5_eddd_nint", n_int, 1);
    reti();
    check_eq("t5_released", n_int, 0);
    do_ack(8'hAA);
    reti();
    check_eq("t5_insvc_clr", inservice, 0);
`endif

    // Reset during ACK drops the vector and all pending requests
    req_frame = 1'b1; req_line = 1'b1; tick();
    req_frame = 1'b0; req_line = 1'b0;
    sb.push_back(8'hA8);
    bus_m1 = 1'b1; bus_iorq = 1'b1; tick();
    check_eq("t6_den_on", d_out_en, 1);
    rst_n = 1'b0; tick();
    check_eq("t6_rst_den", d_out_en, 0);
    check_eq("t6_rst_nint", n_int, 1);
    check_eq("t6_rst_insvc", inservice, 0);
    rst_n = 1'b1; bus_m1 = 1'b0; bus_iorq = 1'b0;
    repeat (4) tick();
    check_eq("t6_no_pend", n_int, 1);
    check_eq("t6_no_vec", d_out_en, 0);
    pulse_frame();
    do_ack(8'hF8);
`ifdef RETI_DECODE_EN
    reti();
`endif

    tick();
    check_eq("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
